// File: rtl/if_id_skid_pkg.sv
// Shared types and constants for the IF/ID boundary: state encoding and the NOP
// instruction presented whenever no entry is held.
package if_id_skid_pkg;

    localparam logic [31:0] INST_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

    function automatic logic [1:0] state_count(input skid_state_e s);
        case (s)
            ST_ONE:  state_count = 2'd1;
            ST_FULL: state_count = 2'd2;
            default: state_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/if_id_skid_dff.sv
// Enabled register with a synchronous set-to-value on rst or clr; rst and clr
// take priority over the load enable.
module dff_en_set #(
    parameter int           W       = 1,
    parameter logic [W-1:0] SET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst_i || clr_i) begin
            q_o <= SET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline boundary with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer (registered ready) or a single pass-through entry.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | nothing held, NOP presented to decode
//   ST_ONE   | main entry valid
//   ST_FULL  | main and skid valid, fetch is stalled
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [DW-1:0] NOP_INST = DW'(INST_NOP),
    parameter bit            SKID     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] inst_addr_i,
    input  logic [DW-1:0] inst_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] inst_addr_o,
    output logic [DW-1:0] inst_o,
    output logic [1:0]    count_o
);

    localparam int EW = AW + DW;

    skid_state_e   state_q, state_d;
    logic [1:0]    state_bits_q;
    logic [EW-1:0] main_q, main_d, skid_q, in_entry;
    logic          main_en, skid_en, main_from_skid;
    logic          accept, out_fire;

    assign in_entry = {inst_addr_i, inst_i};
    assign state_q  = skid_state_e'(state_bits_q);

    assign out_valid_o = (state_q != ST_EMPTY);
    // With SKID the ready depends only on the state register, breaking the
    // combinational path from decode back into fetch.
    assign in_ready_o  = SKID ? (state_q != ST_FULL) : (!out_valid_o || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_en = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && out_fire) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    if (SKID) begin
                        state_d = ST_FULL;
                        skid_en = 1'b1;
                    end
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d        = ST_ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_entry;

    dff_en_set #(.W(2), .SET_VAL(2'(ST_EMPTY))) u_state (
        .clk   (clk),
        .rst_i (rst),
        .clr_i (flush_i),
        .en_i  (1'b1),
        .d_i   (2'(state_d)),
        .q_o   (state_bits_q)
    );

    dff_en_set #(.W(EW), .SET_VAL({{AW{1'b0}}, NOP_INST})) u_main (
        .clk   (clk),
        .rst_i (rst),
        .clr_i (flush_i),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    dff_en_set #(.W(EW), .SET_VAL({{AW{1'b0}}, NOP_INST})) u_skid (
        .clk   (clk),
        .rst_i (rst),
        .clr_i (flush_i),
        .en_i  (skid_en),
        .d_i   (in_entry),
        .q_o   (skid_q)
    );

    // Mask on valid so a decoder that ignores valid still sees a NOP.
    assign inst_addr_o = out_valid_o ? main_q[EW-1:DW] : '0;
    assign inst_o      = out_valid_o ? main_q[DW-1:0]  : NOP_INST;
    assign count_o     = state_count(state_q);

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: directed scenarios plus a random
// valid/ready/flush/reset run against a queue scoreboard.
module tb_if_id_skid;
    import if_id_skid_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_addr, in_inst, out_addr, out_inst;
    logic [1:0]  count;

    logic        v0, rdy0, ov0, r0;
    logic [31:0] a0, d0, addr0, inst0;
    logic [1:0]  cnt0;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    if_id_skid #(.SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_addr_i(in_addr), .inst_i(in_inst),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .inst_addr_o(out_addr), .inst_o(out_inst), .count_o(count)
    );

    if_id_skid #(.SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(1'b0),
        .in_valid_i(v0), .in_ready_o(rdy0),
        .inst_addr_i(a0), .inst_i(d0),
        .out_valid_o(ov0), .out_ready_i(r0),
        .inst_addr_o(addr0), .inst_o(inst0), .count_o(cnt0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven; checks outputs
    // against the scoreboard, advances the model across the next posedge.
    task automatic step(input bit do_chk, output bit acc);
        bit fire;
        #1;
        if (do_chk) begin
            chk("count", 64'(count), 64'(sb.size()));
            chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("addr", 64'(out_addr), 64'(sb[0][63:32]));
                chk("inst", 64'(out_inst), 64'(sb[0][31:0]));
            end else begin
                chk("nop_inst", 64'(out_inst), 64'(INST_NOP));
                chk("nop_addr", 64'(out_addr), 64'd0);
            end
        end
        fire = out_valid && out_ready;
        acc  = in_valid && in_ready && !rst && !flush;
        if (fire && sb.size() != 0) void'(sb.pop_front());
        if (rst || flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back({in_addr, in_inst});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        bit acc;
        in_valid  = 1'b0;
        out_ready = rdy;
        for (int i = 0; i < n; i++) step(1'b1, acc);
    endtask

    // Source holds the entry until accepted; an expired bound counts as a failure.
    task automatic send(input logic [31:0] addr, input logic [31:0] inst, input logic rdy);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            in_valid  = 1'b1;
            in_addr   = addr;
            in_inst   = inst;
            out_ready = rdy;
            step(1'b1, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 64'(addr), 64'hFFFF_FFFF);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_addr = '0; in_inst = '0;
        v0 = 1'b0; r0 = 1'b0; a0 = '0; d0 = '0;
        @(negedge clk);
        step(1'b0, acc);
        step(1'b0, acc);
        rst = 1'b0;

        // reset then idle
        idle(2, 1'b0);

        // single-entry variant: combinational ready pass-through
        v0 = 1'b1; a0 = 32'h300; d0 = 32'h111; r0 = 1'b0;
        #1 chk("s0_rdy_empty", 64'(rdy0), 64'd1);
        @(posedge clk); @(negedge clk);
        a0 = 32'h304; d0 = 32'h222;
        #1 chk("s0_rdy_stall", 64'(rdy0), 64'd0);
        chk("s0_inst_held", 64'(inst0), 64'h111);
        chk("s0_cnt_one", 64'(cnt0), 64'd1);
        r0 = 1'b1;
        #1 chk("s0_rdy_pass", 64'(rdy0), 64'd1);
        @(posedge clk); @(negedge clk);
        v0 = 1'b0;
        #1 chk("s0_inst_new", 64'(inst0), 64'h222);
        chk("s0_addr_new", 64'(addr0), 64'h304);
        chk("s0_cnt_repl", 64'(cnt0), 64'd1);
        @(posedge clk); @(negedge clk);
        #1 chk("s0_valid_drain", 64'(ov0), 64'd0);
        chk("s0_inst_nop", 64'(inst0), 64'(INST_NOP));
        chk("s0_cnt_zero", 64'(cnt0), 64'd0);

        // streaming, back-to-back
        send(32'h0, 32'h00500093, 1'b1);
        send(32'h4, 32'h00A00113, 1'b1);
        send(32'h8, 32'h002081B3, 1'b1);
        idle(2, 1'b1);

        // backpressure: fill, stall the third, then drain in order
        send(32'h100, 32'hA100, 1'b0);
        send(32'h104, 32'hA104, 1'b0);
        in_valid = 1'b1; in_addr = 32'h108; in_inst = 32'hA108;
        step(1'b1, acc);
        step(1'b1, acc);
        send(32'h108, 32'hA108, 1'b1);
        idle(3, 1'b1);

        // flush while full with a valid input in the same cycle
        send(32'h200, 32'hA200, 1'b0);
        send(32'h204, 32'hA204, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_addr = 32'h208; in_inst = 32'hA208; out_ready = 1'b0;
        step(1'b1, acc);
        flush = 1'b0; in_valid = 1'b0;
        idle(3, 1'b1);

        // reset while full with flush asserted
        send(32'h300, 32'hA300, 1'b0);
        send(32'h304, 32'hA304, 1'b0);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_addr = 32'h308;
        step(1'b1, acc);
        rst = 1'b0; flush = 1'b0;
        idle(2, 1'b0);

        // random valid/ready/flush/reset run
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            in_addr   = $urandom;
            in_inst   = $urandom;
            step(1'b1, acc);
        end
        rst = 1'b0; flush = 1'b0;
        idle(4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
